// File: rtl/tri_feeder_pkg.sv
// Shared types and constants for the triangle feeder: vertex layout,
// packed vertex-word field positions and the feeder FSM encoding.
package tri_feeder_pkg;

  localparam int VERT_W = 9;
  localparam int WORD_W = 3 * VERT_W;

  // Bit positions of the three coordinates inside one memory word.
  localparam logic [4:0] X_LSB = 5'd18;
  localparam logic [4:0] Y_LSB = 5'd9;
  localparam logic [4:0] Z_LSB = 5'd0;

  // One vertex: [2]=x, [1]=y, [0]=z.
  typedef logic [VERT_W-1:0] vertex_t [2:0];

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Extract one 9-bit coordinate from a packed vertex word.
  function automatic logic [VERT_W-1:0] word_field(input logic [WORD_W-1:0] word,
                                                   input logic [4:0]        lsb);
    return word[lsb +: VERT_W];
  endfunction

endpackage

// File: rtl/tri_feeder_rd_pipe.sv
// Read-return tracker: delays a valid flag and the vertex slot index of
// each issued read by the memory latency, so the returning word can be
// steered into the right vertex register.
module rd_pipe #(
  parameter int DEPTH  = 2,
  parameter int SLOT_W = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              issue_vld,
  input  logic [SLOT_W-1:0] issue_slot,
  output logic              ret_vld,
  output logic [SLOT_W-1:0] ret_slot
);

  logic              vld_r  [DEPTH];
  logic [SLOT_W-1:0] slot_r [DEPTH];

  // Shift each issued read tag one stage per cycle; reset drops in-flight reads.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_r[i]  <= 1'b0;
        slot_r[i] <= {SLOT_W{1'b0}};
      end
    end else begin
      vld_r[0]  <= issue_vld;
      slot_r[0] <= issue_slot;
      for (int i = 1; i < DEPTH; i++) begin
        vld_r[i]  <= vld_r[i-1];
        slot_r[i] <= slot_r[i-1];
      end
    end
  end

  assign ret_vld  = vld_r[DEPTH-1];
  assign ret_slot = slot_r[DEPTH-1];

endmodule

// File: rtl/tri_feeder.sv
// Triangle feeder: on frame_start, reads NUM_TRIS triangles (three vertex
// words each) from a fixed-latency vertex memory and hands them one at a
// time to a rasterizer with a valid/ready handshake.
module tri_feeder
  import tri_feeder_pkg::*;
#(
  parameter int NUM_TRIS    = 12,
  parameter int BASE_ADDR   = 0,
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 12
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  output vertex_t           vert1,
  output vertex_t           vert2,
  output vertex_t           vert3,
  output logic              valid_tri,
  input  logic              tri_ready,
  output logic              new_frame,
  output logic              obj_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] BASE_V    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [9:0]        LAST_IDX  = 10'(NUM_TRIS - 1);
  localparam logic [1:0]        LAST_SLOT = 2'd2;

  state_e            state_r,     state_nxt_s;
  logic [1:0]        fcnt_r,      fcnt_nxt_s;
  logic [9:0]        idx_r,       idx_nxt_s;
  logic [ADDR_W-1:0] mem_addr_r,  addr_nxt_s;
  logic              valid_r,     valid_nxt_s;
  logic              new_frame_r, new_frame_nxt_s;
  logic              obj_done_r,  obj_done_nxt_s;
  logic              busy_r;
  vertex_t           v1_r, v2_r, v3_r;
  vertex_t           v1_nxt_s, v2_nxt_s, v3_nxt_s;
  vertex_t           word_v_s;
  logic              issue_vld_s;
  logic              ret_vld_s;
  logic [1:0]        ret_slot_s;

  // A read is issued on every FETCH cycle; the fetch counter names its slot.
  assign issue_vld_s = (state_r == ST_FETCH);

  rd_pipe #(
    .DEPTH  (MEM_LATENCY),
    .SLOT_W (2)
  ) u_rd_pipe (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .issue_vld  (issue_vld_s),
    .issue_slot (fcnt_r),
    .ret_vld    (ret_vld_s),
    .ret_slot   (ret_slot_s)
  );

  // Unpack the returning memory word into x/y/z coordinates.
  always_comb begin
    word_v_s[2] = word_field(mem_data, X_LSB);
    word_v_s[1] = word_field(mem_data, Y_LSB);
    word_v_s[0] = word_field(mem_data, Z_LSB);
  end

  // Steer a returning word into the vertex register named by its slot tag.
  always_comb begin
    v1_nxt_s = v1_r;
    v2_nxt_s = v2_r;
    v3_nxt_s = v3_r;
    if (ret_vld_s) begin
      case (ret_slot_s)
        2'd0:    v1_nxt_s = word_v_s;
        2'd1:    v2_nxt_s = word_v_s;
        2'd2:    v3_nxt_s = word_v_s;
        default: v1_nxt_s = v1_r;
      endcase
    end else begin
      v1_nxt_s = v1_r;
    end
  end

  // Sequence fetch, wait-for-data, present and end-of-object handling.
  always_comb begin
    state_nxt_s     = state_r;
    fcnt_nxt_s      = fcnt_r;
    idx_nxt_s       = idx_r;
    addr_nxt_s      = mem_addr_r;
    valid_nxt_s     = valid_r;
    new_frame_nxt_s = 1'b0;
    obj_done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt_s     = ST_FETCH;
          fcnt_nxt_s      = 2'd0;
          idx_nxt_s       = 10'd0;
          addr_nxt_s      = BASE_V;
          new_frame_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (fcnt_r == LAST_SLOT) begin
          state_nxt_s = ST_WAIT;
          fcnt_nxt_s  = 2'd0;
        end else begin
          addr_nxt_s = mem_addr_r + ADDR_ONE;
          fcnt_nxt_s = fcnt_r + 2'd1;
        end
      end
      ST_WAIT: begin
        if (ret_vld_s && (ret_slot_s == LAST_SLOT)) begin
          state_nxt_s = ST_PRESENT;
          valid_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_PRESENT: begin
        if (tri_ready) begin
          valid_nxt_s = 1'b0;
          if (idx_r == LAST_IDX) begin
            state_nxt_s = ST_DONE;
          end else begin
            // mem_addr still holds the third vertex of this triangle,
            // so the next triangle starts one word further on.
            state_nxt_s = ST_FETCH;
            idx_nxt_s   = idx_r + 10'd1;
            addr_nxt_s  = mem_addr_r + ADDR_ONE;
            fcnt_nxt_s  = 2'd0;
          end
        end else begin
          state_nxt_s = ST_PRESENT;
        end
      end
      ST_DONE: begin
        state_nxt_s    = ST_IDLE;
        obj_done_nxt_s = 1'b1;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any object in progress.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r     <= ST_IDLE;
      fcnt_r      <= 2'd0;
      idx_r       <= 10'd0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      valid_r     <= 1'b0;
      new_frame_r <= 1'b0;
      obj_done_r  <= 1'b0;
      busy_r      <= 1'b0;
      v1_r        <= '{default: {VERT_W{1'b0}}};
      v2_r        <= '{default: {VERT_W{1'b0}}};
      v3_r        <= '{default: {VERT_W{1'b0}}};
    end else begin
      state_r     <= state_nxt_s;
      fcnt_r      <= fcnt_nxt_s;
      idx_r       <= idx_nxt_s;
      mem_addr_r  <= addr_nxt_s;
      valid_r     <= valid_nxt_s;
      new_frame_r <= new_frame_nxt_s;
      obj_done_r  <= obj_done_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      v1_r        <= v1_nxt_s;
      v2_r        <= v2_nxt_s;
      v3_r        <= v3_nxt_s;
    end
  end

  assign mem_addr  = mem_addr_r;
  assign valid_tri = valid_r;
  assign new_frame = new_frame_r;
  assign obj_done  = obj_done_r;
  assign busy      = busy_r;
  assign vert1     = v1_r;
  assign vert2     = v2_r;
  assign vert3     = v3_r;

endmodule

// File: tb/tb_tri_feeder.sv
// Bench for tri_feeder: a cycle table on a one-triangle instance, then
// randomized streaming on a twelve-triangle instance checked against a
// transaction-level model of the feeder.
module tb_tri_feeder;
  import tri_feeder_pkg::*;

  localparam int AW    = 12;
  localparam int NT    = 12;
  localparam int BASE1 = 4094;
  localparam logic [26:0] W0 = {9'd20, 9'd20, 9'd0};
  localparam logic [26:0] W1 = {9'd20, 9'd40, 9'd0};
  localparam logic [26:0] W2 = {9'd40, 9'd20, 9'd0};

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          fs12 = 1'b0, tr12 = 1'b0, fs1 = 1'b0, tr1 = 1'b0;
  logic [AW-1:0] addr12, addr1;
  logic [26:0]   data12, data1;
  vertex_t       v1_12, v2_12, v3_12, v1_1, v2_1, v3_1;
  logic          vld12, nf12, od12, busy12, vld1, nf1, od1, busy1;

  tri_feeder #(.NUM_TRIS(NT), .BASE_ADDR(0), .MEM_LATENCY(2), .ADDR_W(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start(fs12), .mem_addr(addr12),
    .mem_data(data12), .vert1(v1_12), .vert2(v2_12), .vert3(v3_12),
    .valid_tri(vld12), .tri_ready(tr12), .new_frame(nf12), .obj_done(od12),
    .busy(busy12));

  tri_feeder #(.NUM_TRIS(1), .BASE_ADDR(BASE1), .MEM_LATENCY(2), .ADDR_W(AW)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start(fs1), .mem_addr(addr1),
    .mem_data(data1), .vert1(v1_1), .vert2(v2_1), .vert3(v3_1),
    .valid_tri(vld1), .tri_ready(tr1), .new_frame(nf1), .obj_done(od1),
    .busy(busy1));

  // Vertex memory with a two-cycle read latency per instance.
  logic [26:0]   mem [4096];
  logic [AW-1:0] a12_d1 = '0, a12_d2 = '0, a1_d1 = '0, a1_d2 = '0;
  always @(posedge clk_in) begin
    a12_d1 <= addr12; a12_d2 <= a12_d1;
    a1_d1  <= addr1;  a1_d2  <= a1_d1;
  end
  assign data12 = mem[a12_d2];
  assign data1  = mem[a1_d2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] vword(input vertex_t v);
    return {v[2], v[1], v[0]};
  endfunction

  // Transaction-level model of the 12-triangle instance.
  logic m_active = 1'b0, m_done = 1'b0, m_valid = 1'b0;
  int   m_k = 0, m_cd = 0, n_xfer = 0, n_nf = 0, n_od = 0;

  function automatic logic [26:0] exp_word(input int k, input int j);
    logic [AW-1:0] a;
    a = AW'(3 * k + j);
    return mem[a];
  endfunction

  task automatic step12(input logic fs, input logic rdy);
    logic xfer, exp_nf, exp_od;
    fs12 = fs; tr12 = rdy;
    xfer = m_valid && rdy;
    exp_nf = 1'b0; exp_od = 1'b0;
    @(posedge clk_in);
    if (m_done) begin
      m_done = 1'b0; exp_od = 1'b1;
    end else if (!m_active) begin
      if (fs) begin m_active = 1'b1; m_k = 0; m_cd = 5; exp_nf = 1'b1; end
    end else if (xfer) begin
      m_valid = 1'b0; n_xfer++;
      if (m_k == NT - 1) begin m_active = 1'b0; m_done = 1'b1; end
      else begin m_k++; m_cd = 5; end
    end else if (!m_valid) begin
      m_cd--;
      if (m_cd == 0) m_valid = 1'b1;
    end
    @(negedge clk_in);
    check("new_frame", nf12, exp_nf);
    check("obj_done", od12, exp_od);
    check("busy", busy12, m_active || m_done);
    check("valid_tri", vld12, m_valid);
    if (exp_nf) check("start_addr", addr12, 0);
    if (m_valid) begin
      check("vert1", vword(v1_12), exp_word(m_k, 0));
      check("vert2", vword(v2_12), exp_word(m_k, 1));
      check("vert3", vword(v3_12), exp_word(m_k, 2));
    end
    if (nf12) n_nf++;
    if (od12) n_od++;
  endtask

  typedef struct {
    logic        fs;
    logic        nf;
    logic        vld;
    logic        od;
    logic        bsy;
    logic        chk_addr;
    logic [11:0] addr;
    logic        chk_v;
  } vec_t;
  vec_t tbl [10];

  initial begin
    int guard;
    for (int a = 0; a < 4096; a++) mem[a] = 27'($urandom);
    mem[4094] = W0; mem[4095] = W1; mem[0] = W2;

    // One-triangle object, timing per cycle after the accepting edge.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd4094, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd4095, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0,    1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0,    1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0,    1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 12'd0,    1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0,    1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0,    1'b0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd4094, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd4095, 1'b0};

    repeat (3) @(negedge clk_in);
    check("rst_busy", {busy12, busy1}, 0);
    check("rst_valid", {vld12, vld1}, 0);
    check("rst_pulses", {nf12, od12, nf1, od1}, 0);
    check("rst_addr", {addr12, addr1}, 0);
    check("rst_verts", {vword(v1_12), vword(v2_12), vword(v3_12)}, 0);
    rst_in = 1'b1;

    tr1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fs1 = tbl[i].fs;
      @(posedge clk_in);
      @(negedge clk_in);
      check($sformatf("tbl%0d_new_frame", i), nf1, tbl[i].nf);
      check($sformatf("tbl%0d_valid", i), vld1, tbl[i].vld);
      check($sformatf("tbl%0d_obj_done", i), od1, tbl[i].od);
      check($sformatf("tbl%0d_busy", i), busy1, tbl[i].bsy);
      if (tbl[i].chk_addr) check($sformatf("tbl%0d_addr", i), addr1, tbl[i].addr);
      if (tbl[i].chk_v) begin
        check("tbl_vert1", vword(v1_1), W0);
        check("tbl_vert2", vword(v2_1), W1);
        check("tbl_vert3", vword(v3_1), W2);
      end
    end
    fs1 = 1'b0;

    // Full object with tri_ready always high and stray frame_start pulses.
    step12(1'b1, 1'b1);
    guard = 0;
    while ((m_active || m_done) && guard < 300) begin
      step12(1'($urandom_range(0, 1)), 1'b1);
      guard++;
    end
    check("phaseA_timeout", guard < 300, 1'b1);
    check("phaseA_transfers", n_xfer, NT);
    check("phaseA_obj_done_count", n_od, 1);
    check("phaseA_new_frame_count", n_nf, 1);

    // Stall the first triangle for 50 cycles, then stream with random ready.
    step12(1'b1, 1'b0);
    guard = 0;
    while (!m_valid && guard < 20) begin step12(1'b0, 1'b0); guard++; end
    check("phaseB_first_valid", m_valid, 1'b1);
    repeat (50) step12(1'($urandom_range(0, 1)), 1'b0);
    step12(1'b0, 1'b1);
    check("phaseB_stall_release", m_k, 1);
    guard = 0;
    while (!(m_k == 5 && m_valid) && guard < 500) begin
      step12(1'b0, 1'($urandom_range(0, 1)));
      guard++;
    end
    check("phaseB_reach_tri5", guard < 500, 1'b1);

    // Asynchronous reset while triangle 5 is presented.
    n_od = 0;
    #2 rst_in = 1'b0;
    #1;
    check("mid_rst_outputs", {vld12, nf12, od12, busy12}, 0);
    check("mid_rst_addr", addr12, 0);
    check("mid_rst_verts", {vword(v1_12), vword(v2_12), vword(v3_12)}, 0);
    m_active = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_k = 0;
    @(negedge clk_in);
    check("mid_rst_hold", {vld12, nf12, od12, busy12}, 0);
    rst_in = 1'b1;

    // Restart after reset: triangle 0 from the base address again.
    n_xfer = 0; n_nf = 0;
    step12(1'b1, 1'($urandom_range(0, 1)));
    guard = 0;
    while ((m_active || m_done) && guard < 1000) begin
      step12(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      guard++;
    end
    check("phaseC_timeout", guard < 1000, 1'b1);
    check("phaseC_transfers", n_xfer, NT);
    check("phaseC_obj_done_count", n_od, 1);
    check("phaseC_new_frame_count", n_nf, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_feeder.md
TRI_FEEDER -- requirements
Module: tri_feeder

Interface
REQ-001 SHALL have parameter NUM_TRIS, default 12, number of triangles per object (legal range 1..1023).
REQ-002 SHALL have parameter BASE_ADDR, default 0, word address of first vertex of the object.
REQ-003 SHALL have parameter MEM_LATENCY, default 2, cycles from mem_addr to matching mem_data.
REQ-004 SHALL have parameter ADDR_W, default 12, vertex memory address width.
REQ-005 clk_in  input  1  system clock; all state on rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-low.
REQ-007 frame_start  input  1  single-cycle request to stream one object.
REQ-008 mem_addr  output  ADDR_W  registered vertex memory read address.
REQ-009 mem_data  input  27  vertex word: [26:18]=vert[2] (x), [17:9]=vert[1] (y), [8:0]=vert[0] (z).
REQ-010 vert1, vert2, vert3  output  3x9 each (unpacked [2:0] of 9 bit)  triangle vertices to rasterizer.
REQ-011 valid_tri  output  1  vertices valid; held until accepted.
REQ-012 tri_ready  input  1  rasterizer accepts current triangle.
REQ-013 new_frame  output  1  one-cycle pulse at start of object stream.
REQ-014 obj_done  output  1  one-cycle pulse after final triangle accepted.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, WAIT, PRESENT, DONE.
REQ-017 IDLE: frame_start=1 sampled -> next cycle new_frame=1, state FETCH, tri index=0, mem_addr=BASE_ADDR.
REQ-018 FETCH: mem_addr SHALL step BASE_ADDR+3*i, +1, +2 on three consecutive cycles, then state WAIT.
REQ-019 WAIT: data returned MEM_LATENCY cycles after each address SHALL be captured into vert1, vert2, vert3 in order; after third capture -> PRESENT.
REQ-020 With MEM_LATENCY=2, valid_tri SHALL rise exactly 6 cycles after the edge sampling frame_start (new_frame on cycle 1).
REQ-021 PRESENT: valid_tri=1; vert1..3 SHALL not change while valid_tri=1 and tri_ready=0.
REQ-022 Transfer occurs on a cycle with valid_tri=1 and tri_ready=1; valid_tri SHALL drop next cycle.
REQ-023 After transfer of triangle i<NUM_TRIS-1: i increments, state FETCH next cycle.
REQ-024 After transfer of triangle NUM_TRIS-1: state DONE, obj_done=1 for exactly one cycle, then IDLE.
REQ-025 tri_ready while valid_tri=0 SHALL have no effect.
REQ-026 frame_start while busy=1 SHALL be ignored (not queued).
REQ-027 frame_start in the DONE cycle SHALL be ignored; accepted from IDLE on the following cycle.
REQ-028 Address arithmetic SHALL be ADDR_W bits, wrapping modulo 2^ADDR_W.
REQ-029 Triangle index counter SHALL be 10 bits; never exceeds NUM_TRIS-1.
REQ-030 new_frame and obj_done SHALL never be high in the same cycle.

Reset
REQ-031 rst_in=0 SHALL asynchronously force state IDLE, tri index 0, mem_addr=0, vert1..3=0, valid_tri=0, new_frame=0, obj_done=0, busy=0.
REQ-032 Reset mid-stream SHALL abort the object with no obj_done; in-flight memory data SHALL be discarded.
REQ-033 First frame_start SHALL be honoured on the first rising edge after rst_in deasserts.

Structure
REQ-034 Shared package SHALL hold VERT_W=9, vertex typedef (logic [8:0] array [2:0]), vertex word field offsets, FSM state enum.
REQ-035 One sub-module rd_pipe SHALL implement a MEM_LATENCY-deep valid/slot-index shift register for read return tracking.

Verification
REQ-036 Reset then frame_start, NUM_TRIS=1, memory words {20,20,0},{20,40,0},{40,20,0}, tri_ready=1 -> new_frame cycle 1, valid_tri cycle 6 with vert1=(20,20,0), vert2=(20,40,0), vert3=(40,20,0), obj_done cycle 8.
REQ-037 NUM_TRIS=12, tri_ready always 1 -> 12 transfers, addresses 0..35 each read once, single obj_done.
REQ-038 tri_ready held 0 for 50 cycles in PRESENT -> valid_tri and vert1..3 stable all 50 cycles; transfer on first tri_ready=1.
REQ-039 frame_start pulses during streaming and in DONE cycle -> ignored; exactly one new_frame per accepted start.
REQ-040 rst_in low during triangle 5 of 12 -> all outputs 0 immediately, no obj_done; new frame_start restarts at triangle 0, mem_addr=BASE_ADDR.
